// File: rtl/pipe_arbiter_if.sv
// Handshake bundle for the two-requester arbiter: two enqueue ports in,
// one forwarded channel out, plus the debug source index and counters.
interface pipe_arbiter_if #(
    parameter int WIDTH = 96,
    parameter int CNTW  = 32
);
    logic             in0_enq_ena;
    logic [WIDTH-1:0] in0_enq_v;
    logic             in0_enq_rdy;
    logic             in1_enq_ena;
    logic [WIDTH-1:0] in1_enq_v;
    logic             in1_enq_rdy;
    logic             pipe_enq_ena;
    logic [WIDTH-1:0] pipe_enq_v;
    logic             pipe_enq_rdy;
    logic             src;
    logic [CNTW-1:0]  cnt0;
    logic [CNTW-1:0]  cnt1;

    modport master (
        output in0_enq_ena, in0_enq_v, in1_enq_ena, in1_enq_v, pipe_enq_rdy,
        input  in0_enq_rdy, in1_enq_rdy, pipe_enq_ena, pipe_enq_v, src, cnt0, cnt1
    );

    modport slave (
        input  in0_enq_ena, in0_enq_v, in1_enq_ena, in1_enq_v, pipe_enq_rdy,
        output in0_enq_rdy, in1_enq_rdy, pipe_enq_ena, pipe_enq_v, src, cnt0, cnt1
    );
endinterface

// File: rtl/pipe_arbiter.sv
// Round-robin arbiter sharing one downstream enqueue channel between two
// producers, each buffered by a one-entry holding register.
module pipe_arbiter #(
    parameter int WIDTH = 96,
    parameter int CNTW  = 32
) (
    input  logic          clk_i,
    input  logic          rst_ni,
    pipe_arbiter_if.slave bus
);
    logic [1:0]       enq_ena;
    logic [WIDTH-1:0] enq_v   [2];
    logic [1:0]       full;
    logic [WIDTH-1:0] bufs    [2];
    logic [CNTW-1:0]  cnts    [2];
    logic             last_q;
    logic             grant;
    logic             xfer;

    assign enq_ena  = {bus.in1_enq_ena, bus.in0_enq_ena};
    assign enq_v[0] = bus.in0_enq_v;
    assign enq_v[1] = bus.in1_enq_v;

    // A tie goes to whichever requester was not granted last.
    always_comb begin
        grant = 1'b0;
        case (full)
            2'b01:   grant = 1'b0;
            2'b10:   grant = 1'b1;
            2'b11:   grant = ~last_q;
            default: grant = 1'b0;
        endcase
    end

    assign xfer = (|full) & bus.pipe_enq_rdy;

    genvar gi;
    generate
        for (gi = 0; gi < 2; gi++) begin : g_req
            localparam logic IDX = 1'(gi);
            logic             full_q, full_d;
            logic [WIDTH-1:0] buf_q, buf_d;
            logic [CNTW-1:0]  cnt_q, cnt_d;
            logic             drain;

            assign drain = xfer && (grant == IDX);

            // Drain and fill are exclusive: a full slot never accepts.
            always_comb begin
                full_d = full_q;
                buf_d  = buf_q;
                cnt_d  = cnt_q;
                if (drain) begin
                    full_d = 1'b0;
                    cnt_d  = cnt_q + CNTW'(1);
                end else if (enq_ena[gi] && !full_q) begin
                    full_d = 1'b1;
                    buf_d  = enq_v[gi];
                end
            end

            always_ff @(posedge clk_i or negedge rst_ni) begin
                if (!rst_ni) begin
                    full_q <= 1'b0;
                    buf_q  <= '0;
                    cnt_q  <= '0;
                end else begin
                    full_q <= full_d;
                    buf_q  <= buf_d;
                    cnt_q  <= cnt_d;
                end
            end

            assign full[gi] = full_q;
            assign bufs[gi] = buf_q;
            assign cnts[gi] = cnt_q;
        end
    endgenerate

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            last_q <= 1'b1;
        end else if (xfer) begin
            last_q <= grant;
        end
    end

    assign bus.in0_enq_rdy  = ~full[0];
    assign bus.in1_enq_rdy  = ~full[1];
    assign bus.pipe_enq_ena = xfer;
    assign bus.pipe_enq_v   = grant ? bufs[1] : bufs[0];
    assign bus.src          = grant;
    assign bus.cnt0         = cnts[0];
    assign bus.cnt1         = cnts[1];
endmodule

// File: tb/tb_pipe_arbiter.sv
// Self-checking bench: directed vector table, hand-written corner sequences
// and a randomized run against a slot-level reference model.
module tb_pipe_arbiter;
    localparam int W  = 96;
    localparam int CW = 4;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;

    pipe_arbiter_if #(.WIDTH(W), .CNTW(CW)) bus ();
    pipe_arbiter #(.WIDTH(W), .CNTW(CW)) dut (
        .clk_i  (clk),
        .rst_ni (rst_n),
        .bus    (bus)
    );

    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_bad = 0;

    task automatic chk(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic e0, input logic [W-1:0] v0, input logic e1,
                         input logic [W-1:0] v1, input logic prdy);
        bus.in0_enq_ena  = e0;
        bus.in0_enq_v    = v0;
        bus.in1_enq_ena  = e1;
        bus.in1_enq_v    = v1;
        bus.pipe_enq_rdy = prdy;
    endtask

    task automatic chk_all(input string tag, input logic r0, input logic r1, input logic ena,
                           input logic [W-1:0] v, input logic s, input logic [CW-1:0] c0,
                           input logic [CW-1:0] c1);
        chk({tag, ".rdy0"}, W'(bus.in0_enq_rdy), W'(r0));
        chk({tag, ".rdy1"}, W'(bus.in1_enq_rdy), W'(r1));
        chk({tag, ".ena"},  W'(bus.pipe_enq_ena), W'(ena));
        chk({tag, ".v"},    bus.pipe_enq_v, v);
        chk({tag, ".src"},  W'(bus.src), W'(s));
        chk({tag, ".cnt0"}, W'(bus.cnt0), W'(c0));
        chk({tag, ".cnt1"}, W'(bus.cnt1), W'(c1));
    endtask

    typedef struct {
        logic           e0;
        logic [W-1:0]   v0;
        logic           e1;
        logic [W-1:0]   v1;
        logic           prdy;
        logic           x_rdy0;
        logic           x_rdy1;
        logic           x_ena;
        logic [W-1:0]   x_v;
        logic           x_src;
        logic [CW-1:0]  x_c0;
        logic [CW-1:0]  x_c1;
    } vec_t;

    localparam logic [W-1:0] A = 96'hA;
    localparam logic [W-1:0] B = 96'hB;
    localparam logic [W-1:0] C = 96'hC0FFEE_0000_0000_0000_0C;
    localparam logic [W-1:0] D = 96'hDEAD_BEEF_0000_0000_000D;
    localparam logic [W-1:0] E = 96'hE;
    localparam logic [W-1:0] Z = '0;
    localparam logic [W-1:0] ONE = 96'h1;

    vec_t vt [14];

    // Reference model state: one slot per requester plus round-robin pointer.
    logic         m_full [2];
    logic [W-1:0] m_buf  [2];
    int           m_last;
    int           m_cnt  [2];

    task automatic model_reset();
        for (int i = 0; i < 2; i++) begin
            m_full[i] = 1'b0;
            m_buf[i]  = '0;
            m_cnt[i]  = 0;
        end
        m_last = 1;
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        #2;
        rst_n = 1'b1;
        tick();
    endtask

    initial begin
        drive(1'b0, Z, 1'b0, Z, 1'b0);

        vt[0]  = '{1'b0, Z,   1'b0, Z, 1'b1, 1'b1, 1'b1, 1'b0, Z,   1'b0, 4'd0, 4'd0};
        vt[1]  = '{1'b1, ONE, 1'b0, Z, 1'b1, 1'b1, 1'b1, 1'b0, Z,   1'b0, 4'd0, 4'd0};
        vt[2]  = '{1'b0, Z,   1'b0, Z, 1'b1, 1'b0, 1'b1, 1'b1, ONE, 1'b0, 4'd0, 4'd0};
        vt[3]  = '{1'b1, A,   1'b1, B, 1'b1, 1'b1, 1'b1, 1'b0, ONE, 1'b0, 4'd1, 4'd0};
        vt[4]  = '{1'b0, Z,   1'b0, Z, 1'b1, 1'b0, 1'b0, 1'b1, B,   1'b1, 4'd1, 4'd0};
        vt[5]  = '{1'b0, Z,   1'b0, Z, 1'b1, 1'b0, 1'b1, 1'b1, A,   1'b0, 4'd1, 4'd1};
        vt[6]  = '{1'b1, C,   1'b1, D, 1'b0, 1'b1, 1'b1, 1'b0, A,   1'b0, 4'd2, 4'd1};
        vt[7]  = '{1'b0, Z,   1'b0, Z, 1'b0, 1'b0, 1'b0, 1'b0, D,   1'b1, 4'd2, 4'd1};
        vt[8]  = '{1'b0, Z,   1'b0, Z, 1'b0, 1'b0, 1'b0, 1'b0, D,   1'b1, 4'd2, 4'd1};
        vt[9]  = '{1'b0, Z,   1'b0, Z, 1'b0, 1'b0, 1'b0, 1'b0, D,   1'b1, 4'd2, 4'd1};
        vt[10] = '{1'b0, Z,   1'b0, Z, 1'b1, 1'b0, 1'b0, 1'b1, D,   1'b1, 4'd2, 4'd1};
        vt[11] = '{1'b0, Z,   1'b1, E, 1'b1, 1'b0, 1'b1, 1'b1, C,   1'b0, 4'd2, 4'd2};
        vt[12] = '{1'b0, Z,   1'b0, Z, 1'b1, 1'b1, 1'b0, 1'b1, E,   1'b1, 4'd3, 4'd2};
        vt[13] = '{1'b0, Z,   1'b0, Z, 1'b1, 1'b1, 1'b1, 1'b0, C,   1'b0, 4'd3, 4'd3};

        // Reset held: outputs in their cleared state.
        repeat (2) @(posedge clk);
        #1;
        chk_all("reset", 1'b1, 1'b1, 1'b0, Z, 1'b0, 4'd0, 4'd0);
        rst_n = 1'b1;
        tick();

        // Directed vector table.
        for (int i = 0; i < 14; i++) begin
            drive(vt[i].e0, vt[i].v0, vt[i].e1, vt[i].v1, vt[i].prdy);
            @(negedge clk);
            $display("vec %0d: e0=%0b e1=%0b prdy=%0b -> ena=%0b src=%0b v=%0h cnt=%0d/%0d",
                     i, vt[i].e0, vt[i].e1, vt[i].prdy, bus.pipe_enq_ena, bus.src,
                     bus.pipe_enq_v, bus.cnt0, bus.cnt1);
            chk_all($sformatf("vec%0d", i), vt[i].x_rdy0, vt[i].x_rdy1, vt[i].x_ena,
                    vt[i].x_v, vt[i].x_src, vt[i].x_c0, vt[i].x_c1);
            tick();
        end

        // Fresh reset, simultaneous first requests: requester 0 wins the tie.
        drive(1'b0, Z, 1'b0, Z, 1'b1);
        do_reset();
        drive(1'b1, A, 1'b1, B, 1'b1);
        tick();
        drive(1'b0, Z, 1'b0, Z, 1'b1);
        @(negedge clk);
        $display("tie: ena=%0b src=%0b v=%0h", bus.pipe_enq_ena, bus.src, bus.pipe_enq_v);
        chk("tie1.ena", W'(bus.pipe_enq_ena), W'(1'b1));
        chk("tie1.v", bus.pipe_enq_v, A);
        chk("tie1.src", W'(bus.src), W'(1'b0));
        tick();
        @(negedge clk);
        $display("tie: ena=%0b src=%0b v=%0h", bus.pipe_enq_ena, bus.src, bus.pipe_enq_v);
        chk("tie2.v", bus.pipe_enq_v, B);
        chk("tie2.src", W'(bus.src), W'(1'b1));
        tick();
        @(negedge clk);
        chk("tie3.ena", W'(bus.pipe_enq_ena), W'(1'b0));
        chk("tie3.cnt0", W'(bus.cnt0), W'(4'd1));
        chk("tie3.cnt1", W'(bus.cnt1), W'(4'd1));
        tick();

        // Sustained contention: refill as soon as RDY; grants alternate every cycle.
        do_reset();
        drive(1'b1, A, 1'b1, B, 1'b1);
        tick();
        for (int k = 0; k < 20; k++) begin
            drive(bus.in0_enq_rdy, W'($urandom()), bus.in1_enq_rdy, W'($urandom()), 1'b1);
            @(negedge clk);
            $display("rr %0d: ena=%0b src=%0b", k, bus.pipe_enq_ena, bus.src);
            chk($sformatf("rr%0d.ena", k), W'(bus.pipe_enq_ena), W'(1'b1));
            chk($sformatf("rr%0d.src", k), W'(bus.src), W'(k % 2));
            tick();
        end
        drive(1'b0, Z, 1'b0, Z, 1'b0);
        @(negedge clk);
        chk("rr.cnt0", W'(bus.cnt0), W'(4'd10));
        chk("rr.cnt1", W'(bus.cnt1), W'(4'd10));
        tick();

        // Counter wrap on requester 1 (CNTW=4).
        do_reset();
        for (int i = 0; i < 16; i++) begin
            drive(1'b0, Z, 1'b1, W'(i), 1'b1);
            tick();
            drive(1'b0, Z, 1'b0, Z, 1'b1);
            tick();
            $display("wrap %0d: cnt1=%0d", i, bus.cnt1);
            chk($sformatf("wrap%0d.cnt1", i), W'(bus.cnt1), W'((i + 1) % 16));
        end

        // Asynchronous reset mid-cycle with both buffers full.
        drive(1'b1, C, 1'b1, D, 1'b0);
        tick();
        drive(1'b0, Z, 1'b0, Z, 1'b0);
        @(negedge clk);
        chk("arst.pre_rdy0", W'(bus.in0_enq_rdy), W'(1'b0));
        chk("arst.pre_rdy1", W'(bus.in1_enq_rdy), W'(1'b0));
        bus.pipe_enq_rdy = 1'b1;
        rst_n = 1'b0;
        #1;
        $display("arst: ena=%0b rdy=%0b%0b v=%0h", bus.pipe_enq_ena, bus.in1_enq_rdy,
                 bus.in0_enq_rdy, bus.pipe_enq_v);
        chk_all("arst", 1'b1, 1'b1, 1'b0, Z, 1'b0, 4'd0, 4'd0);
        #1;
        rst_n = 1'b1;
        for (int i = 0; i < 2; i++) begin
            tick();
            @(negedge clk);
            chk($sformatf("arst.post%0d.ena", i), W'(bus.pipe_enq_ena), W'(1'b0));
            chk($sformatf("arst.post%0d.cnt0", i), W'(bus.cnt0), W'(4'd0));
        end
        tick();

        // Randomized run against the slot-level model.
        do_reset();
        model_reset();
        for (int cyc = 0; cyc < 600; cyc++) begin
            logic         e0, e1, prdy, x_ena;
            logic [W-1:0] v0, v1, x_v;
            int           g;
            e0   = !m_full[0] && ($urandom_range(0, 1) == 1);
            e1   = !m_full[1] && ($urandom_range(0, 1) == 1);
            v0   = {$urandom(), $urandom(), $urandom()};
            v1   = {$urandom(), $urandom(), $urandom()};
            prdy = ($urandom_range(0, 3) != 0);
            drive(e0, v0, e1, v1, prdy);

            if (m_full[0] && m_full[1]) g = 1 - m_last;
            else if (m_full[1])         g = 1;
            else                        g = 0;
            x_ena = (m_full[0] || m_full[1]) && prdy;
            x_v   = m_buf[g];

            @(negedge clk);
            if (x_ena)
                $display("rnd %0d: fwd src=%0d v=%0h", cyc, g, x_v);
            chk_all($sformatf("rnd%0d", cyc), !m_full[0], !m_full[1], x_ena, x_v,
                    1'(g), CW'(m_cnt[0] % 16), CW'(m_cnt[1] % 16));

            if (x_ena) begin
                m_full[g] = 1'b0;
                m_last    = g;
                m_cnt[g]++;
            end
            if (e0) begin m_full[0] = 1'b1; m_buf[0] = v0; end
            if (e1) begin m_full[1] = 1'b1; m_buf[1] = v1; end
            tick();
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule

// File: doc/pipe_arbiter.md
# pipe_arbiter

Two-requester round-robin arbiter that shares one downstream 96-bit `pipe$enq` channel, such as the indication pipe feeding an `EchoIndicationInput`, between two independent producers (for example two `EchoIndicationOutput` instances). Each requester port has a one-entry holding register, so accepting a request never depends combinationally on the downstream channel. The block sits between the producers' `pipe$enq` outputs and the single consumer. It also keeps per-source forwarded-message counters for debug.

## Interface
- WIDTH, 96, payload width of every `enq$v` bus.
- CNTW, 32, width of each forwarded-message counter.

Ports:
- CLK  input  1  clock, rising edge.
- nRST  input  1  reset, asynchronous, active-low.
- in0$enq__ENA  input  1  requester 0 enqueue; asserted only while in0$enq__RDY=1.
- in0$enq$v  input  WIDTH  requester 0 payload.
- in0$enq__RDY  output  1  requester 0 holding register empty.
- in1$enq__ENA  input  1  requester 1 enqueue; asserted only while in1$enq__RDY=1.
- in1$enq$v  input  WIDTH  requester 1 payload.
- in1$enq__RDY  output  1  requester 1 holding register empty.
- pipe$enq__ENA  output  1  forward one payload downstream.
- pipe$enq$v  output  WIDTH  forwarded payload.
- pipe$enq__RDY  input  1  downstream can accept.
- src  output  1  source of the current pipe$enq$v (0/1); valid when pipe$enq__ENA=1.
- cnt0  output  CNTW  messages forwarded from requester 0.
- cnt1  output  CNTW  messages forwarded from requester 1.

## Operation
- State per requester N: buf N (WIDTH), full N (1). Shared state: last (1, index of the last granted requester), cnt0, cnt1.
- inN$enq__RDY = !fullN. It is registered-state only and has no bypass from the downstream channel.
- On inN$enq__ENA: bufN <= inN$enq$v and fullN <= 1. ENA while fullN=1 is a protocol violation; the block ignores it, keeping bufN and fullN unchanged.
- Grant selection, combinational:
  - Only full0: grant 0.
  - Only full1: grant 1.
  - Both full: grant !last.
  - Neither full: no grant.
- pipe$enq__ENA = (full0 | full1) & pipe$enq__RDY.
- pipe$enq$v = buf[grant]; src = grant. When neither is full, pipe$enq$v = buf0 and src = 0.
- On transfer (pipe$enq__ENA=1):
  - fullgrant <= 0.
  - last <= grant.
  - cntgrant <= cntgrant + 1, modulo 2^CNTW, wrapping to 0 silently.
- An enqueue into requester M and a transfer from requester N≠M in the same cycle both take effect.
- Requester N cannot enqueue and drain in the same cycle, because RDY=0 while full.
- Reset (nRST=0), asynchronous, any time:
  - full0=full1=0, buf0=buf1=0, last=1 (requester 0 wins the first tie), cnt0=cnt1=0.
  - Any pending payloads are discarded.
- Output values during and after reset: in0$enq__RDY=1, in1$enq__RDY=1, pipe$enq__ENA=0, pipe$enq$v=0, src=0, cnt0=0, cnt1=0.

## Timing
- Latency: a payload enqueued in cycle t can be forwarded no earlier than cycle t+1, and only if pipe$enq__RDY=1 in that cycle.
- Per-requester throughput: at most 1 message per 2 cycles (fill, then drain).
- Aggregate throughput: 1 message per cycle when both requesters are active and downstream is always ready.
- Fairness: with both requesters continuously full, grants alternate 0,1,0,1,… Neither requester waits more than one other transfer once it is full.
- Combinational paths:
  - pipe$enq__RDY → pipe$enq__ENA (allowed).
  - No path from inN$enq__ENA or inN$enq$v to any output.
- Downstream stall: while pipe$enq__RDY=0, buffers, last and counters hold. pipe$enq$v and src stay stable, showing the pending grant.

## Test plan
- Reset release, idle: both inN$enq__RDY=1, pipe$enq__ENA=0, cnt0=cnt1=0. Assert nRST=0 asynchronously mid-cycle and confirm outputs clear without a clock edge.
- Single source, pipe$enq__RDY=1:
  - Enqueue 96'h1 on in0 at t. Required: pipe$enq__ENA=1 with v=96'h1 and src=0 at t+1; in0$enq__RDY=0 at t+1 and 1 at t+2; cnt0=1.
- Simultaneous first requests:
  - Enqueue in0=96'hA and in1=96'hB at the same cycle t.
  - Required: forward A (src=0) at t+1, then B (src=1) at t+2; cnt0=1, cnt1=1.
- Sustained contention:
  - Refill each requester as soon as its RDY is 1, for 20 cycles.
  - Required: src alternates 0,1,0,1 every cycle after the first transfer; cnt0 and cnt1 differ by at most 1.
- Downstream stall:
  - Hold pipe$enq__RDY=0 for 5 cycles with both buffers full.
  - Required: pipe$enq__ENA=0, counters frozen, both RDY=0.
  - Release: the non-last requester drains first.
- Counter wrap and mid-operation reset:
  - Preload cnt1 to 2^CNTW−1 via a long run (or use CNTW=4). One more transfer gives cnt1=0.
  - Assert nRST with both buffers full. Required: buffers are discarded and no transfer occurs after release.
